// File: rtl/branch_unit_stk.sv
// Branch decision unit with an internal flags register and return-address stack.
// Registers one decision and target per requesting cycle; the PC loads target_o when branch_o=1.
module branch_unit_stk #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        op_i,
  input  logic              ctrl_jmp_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  input  logic              flag_we_i,
  input  logic              flag_z_i,
  input  logic              flag_c_i,
  input  logic              flag_n_i,
  output logic              branch_o,
  output logic [ADDR_W-1:0] target_o,
  output logic [2:0]        flags_o,
  output logic [SP_W-1:0]   sp_o,
  output logic              stk_empty_o,
  output logic              stk_full_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_JN   = 4'h7;
  localparam logic [3:0] OP_CALL = 4'h8;
  localparam logic [3:0] OP_RET  = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_JNC  = 4'hE;
  localparam logic [3:0] OP_JNN  = 4'hF;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic              cond_taken;
  logic              is_call;
  logic              is_ret;
  logic              stk_is_full;
  logic              stk_is_empty;
  logic              push;
  logic              pop;
  logic              fault;
  logic              taken;
  logic [ADDR_W-1:0] target_next;
  logic [SP_W-1:0]   sp_next;
  logic [IDX_W-1:0]  top_idx;

  // flags_o packs {N,C,Z}; conditions always see the pre-edge flags
  logic flag_z, flag_c, flag_n;
  assign flag_z = flags_o[0];
  assign flag_c = flags_o[1];
  assign flag_n = flags_o[2];

  // Decode opcode, qualify stack operations and select the next target
  always_comb begin
    cond_taken   = 1'b0;
    is_call      = 1'b0;
    is_ret       = 1'b0;
    case (op_i)
      OP_JMP:  cond_taken = 1'b1;
      OP_JZ:   cond_taken = flag_z;
      OP_JC:   cond_taken = flag_c;
      OP_JN:   cond_taken = flag_n;
      OP_JNZ:  cond_taken = ~flag_z;
      OP_JNC:  cond_taken = ~flag_c;
      OP_JNN:  cond_taken = ~flag_n;
      OP_CALL: is_call    = 1'b1;
      OP_RET:  is_ret     = 1'b1;
      default: cond_taken = 1'b0;
    endcase

    stk_is_full  = (sp_o == SP_W'(STACK_DEPTH));
    stk_is_empty = (sp_o == SP_W'(0));
    push         = ctrl_jmp_i & is_call & ~stk_is_full;
    pop          = ctrl_jmp_i & is_ret & ~stk_is_empty;
    fault        = ctrl_jmp_i & ((is_call & stk_is_full) | (is_ret & stk_is_empty));
    taken        = (ctrl_jmp_i & cond_taken) | push | pop;

    top_idx      = IDX_W'(sp_o - SP_W'(1));
    target_next  = pop ? stack[top_idx] : target_i;

    sp_next      = sp_o;
    if (push)      sp_next = sp_o + SP_W'(1);
    else if (pop)  sp_next = sp_o - SP_W'(1);
  end

  // Decision, target, flags, pointer and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_o    <= 1'b0;
      target_o    <= '0;
      flags_o     <= 3'b000;
      sp_o        <= '0;
      stk_empty_o <= 1'b1;
      stk_full_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      branch_o    <= taken;
      if (taken)     target_o <= target_next;
      if (flag_we_i) flags_o  <= {flag_n_i, flag_c_i, flag_z_i};
      sp_o        <= sp_next;
      stk_empty_o <= (sp_next == SP_W'(0));
      stk_full_o  <= (sp_next == SP_W'(STACK_DEPTH));
      if (fault)     err_o    <= 1'b1;
    end
  end

  // Return-address storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) stack[IDX_W'(sp_o)] <= ret_addr_i;
  end

endmodule

// File: tb/tb_branch_unit_stk.sv
// Self-checking bench for branch_unit_stk: directed plan steps followed by random traffic
// compared against a queue-based reference model.
module tb_branch_unit_stk;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SP_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        op;
  logic              ctrl_jmp;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ret_addr;
  logic              flag_we, flag_z, flag_c, flag_n;
  logic              branch;
  logic [ADDR_W-1:0] target_q;
  logic [2:0]        flags;
  logic [SP_W-1:0]   sp;
  logic              stk_empty, stk_full, err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit              m_branch;
  bit [ADDR_W-1:0] m_target;
  bit [2:0]        m_flags;   // {N,C,Z}
  bit              m_err;
  bit [ADDR_W-1:0] m_stk [$];

  always #5 clk = ~clk;

  branch_unit_stk #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .ctrl_jmp_i(ctrl_jmp),
    .target_i(target), .ret_addr_i(ret_addr), .flag_we_i(flag_we),
    .flag_z_i(flag_z), .flag_c_i(flag_c), .flag_n_i(flag_n),
    .branch_o(branch), .target_o(target_q), .flags_o(flags), .sp_o(sp),
    .stk_empty_o(stk_empty), .stk_full_o(stk_full), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one clock of the block expressed as instruction semantics
  task automatic model(input bit r, input bit c, input bit [3:0] o, input bit [7:0] t,
                       input bit [7:0] ra, input bit we, input bit z, input bit cy, input bit n);
    bit zf, cf, nf, take;
    if (r) begin
      m_branch = 0; m_target = '0; m_flags = 3'b000; m_err = 0; m_stk.delete();
      return;
    end
    zf = m_flags[0]; cf = m_flags[1]; nf = m_flags[2];
    m_branch = 0;
    if (c) begin
      take = 0;
      case (o)
        4'h4: take = 1;
        4'h5: take = zf;
        4'h6: take = cf;
        4'h7: take = nf;
        4'hD: take = !zf;
        4'hE: take = !cf;
        4'hF: take = !nf;
        4'h8: if (m_stk.size() < DEPTH) begin m_stk.push_back(ra); take = 1; end
              else m_err = 1;
        4'h9: if (m_stk.size() > 0) begin m_branch = 1; m_target = m_stk.pop_back(); end
              else m_err = 1;
        default: take = 0;
      endcase
      if (take) begin m_branch = 1; m_target = t; end
    end
    if (we) m_flags = {n, cy, z};
  endtask

  task automatic step(input bit r, input bit c, input bit [3:0] o, input bit [7:0] t,
                      input bit [7:0] ra, input bit we, input bit z, input bit cy, input bit n);
    @(negedge clk);
    rst = r; ctrl_jmp = c; op = o; target = t; ret_addr = ra;
    flag_we = we; flag_z = z; flag_c = cy; flag_n = n;
    model(r, c, o, t, ra, we, z, cy, n);
    @(posedge clk);
    #1;
    chk("branch", 32'(branch), 32'(m_branch));
    chk("target", 32'(target_q), 32'(m_target));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("sp", 32'(sp), 32'(m_stk.size()));
    chk("empty", 32'(stk_empty), 32'(m_stk.size() == 0));
    chk("full", 32'(stk_full), 32'(m_stk.size() == DEPTH));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Shorthands for the directed plan
  task automatic jmp(input bit [3:0] o, input bit [7:0] t);
    step(0, 1, o, t, 8'h00, 0, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 0);
  endtask
  task automatic setf(input bit z, input bit cy, input bit n);
    step(0, 0, 4'h0, 8'h00, 8'h00, 1, z, cy, n);
  endtask
  task automatic call(input bit [7:0] t, input bit [7:0] ra);
    step(0, 1, 4'h8, t, ra, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; ctrl_jmp = 0; op = '0; target = '0; ret_addr = '0;
    flag_we = 0; flag_z = 0; flag_c = 0; flag_n = 0;

    // Reset state
    step(1, 0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 0);
    chk("rst_branch", 32'(branch), 32'd0);
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_empty", 32'(stk_empty), 32'd1);

    // Unconditional jump, then one-cycle pulse
    jmp(4'h4, 8'h3A);
    chk("jmp_taken", 32'(branch), 32'd1);
    chk("jmp_target", 32'(target_q), 32'h3A);
    idle();
    chk("jmp_drop", 32'(branch), 32'd0);
    chk("jmp_hold", 32'(target_q), 32'h3A);

    // Z flag jumps, old flags decide on simultaneous load
    setf(1, 0, 0);
    jmp(4'h5, 8'h10);
    chk("jz_taken", 32'(branch), 32'd1);
    chk("jz_target", 32'(target_q), 32'h10);
    jmp(4'hD, 8'h20);
    chk("jnz_not", 32'(branch), 32'd0);
    chk("jnz_hold", 32'(target_q), 32'h10);
    step(0, 1, 4'h5, 8'h30, 8'h00, 1, 0, 0, 0);
    chk("jz_oldflag", 32'(branch), 32'd1);
    chk("jz_oldflag_t", 32'(target_q), 32'h30);
    chk("flags_loaded", 32'(flags), 32'd0);

    // Non-branch opcode and carry jumps
    setf(1, 1, 1);
    jmp(4'h2, 8'h44);
    chk("lda_not", 32'(branch), 32'd0);
    setf(1, 0, 1);
    jmp(4'h6, 8'h55);
    chk("jc_not", 32'(branch), 32'd0);
    jmp(4'hE, 8'h66);
    chk("jnc_taken", 32'(branch), 32'd1);

    // Nested CALL / RET
    call(8'h40, 8'h05);
    call(8'h50, 8'h41);
    chk("call_sp2", 32'(sp), 32'd2);
    jmp(4'h9, 8'h00);
    chk("ret1_t", 32'(target_q), 32'h41);
    chk("ret1_sp", 32'(sp), 32'd1);
    jmp(4'h9, 8'h00);
    chk("ret2_t", 32'(target_q), 32'h05);
    chk("ret2_empty", 32'(stk_empty), 32'd1);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) call(8'h80 + 8'(i), 8'h10 + 8'(i));
    chk("ovf_branch", 32'(branch), 32'd0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd4);
    chk("ovf_full", 32'(stk_full), 32'd1);
    for (int i = 0; i < 4; i++) jmp(4'h9, 8'h00);
    chk("pop_last", 32'(target_q), 32'h10);
    jmp(4'h9, 8'h00);
    chk("unf_branch", 32'(branch), 32'd0);
    chk("unf_err", 32'(err), 32'd1);

    // Reset aborts a pending RET
    step(1, 0, 4'h0, 8'h00, 8'h00, 0, 0, 0, 0);
    call(8'hA0, 8'h01);
    call(8'hB0, 8'h02);
    jmp(4'h9, 8'h00);
    chk("ret_b2b", 32'(target_q), 32'h02);
    call(8'hC0, 8'h03);
    step(1, 1, 4'h9, 8'h00, 8'h00, 1, 1, 1, 1);
    chk("rstabort_br", 32'(branch), 32'd0);
    chk("rstabort_sp", 32'(sp), 32'd0);
    chk("rstabort_fl", 32'(flags), 32'd0);
    chk("rstabort_err", 32'(err), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit [3:0] o;
      o = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'h8 : 4'h9);
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), o,
           8'($urandom), 8'($urandom), ($urandom_range(0, 2) == 0),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
